// File: rtl/ivector_driver_if.sv
// Purpose: groups the start, say-request, heard-indication and status signals of ivector_driver.
// Latency: n/a (wires only).
// Backpressure: start and say are ENA/RDY handshakes; heard is accepted only while ind_heard__RDY=1.
// Ports: master = driver side (ivector_driver), slave = environment (requester + responder).
interface ivector_driver_if;
    // start a run
    logic       start__ENA;
    logic [7:0] start_count;
    logic       start__RDY;
    // outgoing say requests
    logic       request_say__ENA;
    logic [5:0] request_say_meth;
    logic [3:0] request_say_v;
    logic       request_say__RDY;
    // returning heard indications
    logic       ind_heard__ENA;
    logic [5:0] ind_heard_meth;
    logic [3:0] ind_heard_v;
    logic       ind_heard__RDY;
    // run status
    logic       done;
    logic       pass;
    logic       timeout;
    logic [7:0] err_count;

    modport master (
        input  start__ENA, start_count, request_say__RDY,
               ind_heard__ENA, ind_heard_meth, ind_heard_v,
        output start__RDY, request_say__ENA, request_say_meth, request_say_v,
               ind_heard__RDY, done, pass, timeout, err_count
    );

    modport slave (
        output start__ENA, start_count, request_say__RDY,
               ind_heard__ENA, ind_heard_meth, ind_heard_v,
        input  start__RDY, request_say__ENA, request_say_meth, request_say_v,
               ind_heard__RDY, done, pass, timeout, err_count
    );
endinterface

// File: rtl/ivector_driver.sv
// Purpose: issues a run of numbered say requests, checks each returning heard against the issued value.
// Latency: say issued combinationally in the cycle RDY is seen; heard compared in its handshake cycle.
// Backpressure: stalls says on request_say__RDY=0 or DEPTH outstanding; watchdog aborts a stuck run.
// Ports: CLK, nRST (sync, active-low), bus (ivector_driver_if.master: start, say, heard, status).
module ivector_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic               CLK,
    input  logic               nRST,
    ivector_driver_if.master   bus
);

    localparam int             AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    L_FULL     = (AW + 1)'(DEPTH);
    localparam logic [15:0]    L_TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_seq;
    logic [7:0]     r_count;
    logic [AW:0]    r_out;
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [9:0]     r_fifo [DEPTH];
    logic [15:0]    r_wdog;
    logic [7:0]     r_err;
    logic           r_timeout;

    logic           w_start_acc;
    logic           w_active;
    logic           w_say_fire;
    logic           w_heard_rdy;
    logic           w_heard_fire;
    logic           w_mismatch;
    logic           w_wdog_cnt;
    logic           w_wdog_expire;
    logic [AW:0]    w_out_nxt;
    logic [5:0]     w_say_meth;
    logic [3:0]     w_say_v;

    assign w_start_acc  = bus.start__ENA && (r_state == S_IDLE || r_state == S_DONE);
    assign w_active     = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_say_fire   = (r_state == S_RUN) && (r_seq != r_count) &&
                          (r_out != L_FULL) && bus.request_say__RDY;
    assign w_heard_rdy  = (r_out != '0);
    assign w_heard_fire = bus.ind_heard__ENA && w_heard_rdy;
    assign w_mismatch   = w_heard_fire &&
                          (r_fifo[r_rptr] != {bus.ind_heard_v, bus.ind_heard_meth});
    // Watchdog only counts while something is actually owed to us.
    assign w_wdog_cnt    = w_active && w_heard_rdy && !w_heard_fire;
    assign w_wdog_expire = w_wdog_cnt && (r_wdog == L_TMO_LAST);
    // Push and pop in the same cycle cancel out, so a pop is legal even when full.
    assign w_out_nxt    = r_out + {{AW{1'b0}}, w_say_fire} - {{AW{1'b0}}, w_heard_fire};

    assign w_say_meth   = r_seq[5:0];
    assign w_say_v      = r_seq[3:0] ^ 4'b0101;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_acc) begin
                    w_state_nxt = (bus.start_count == 8'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_wdog_expire) begin
                    w_state_nxt = S_DONE;
                end else if (w_say_fire && ((r_seq + 8'd1) == r_count)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Looks at the post-update count so a final heard lands us in DONE next cycle.
                if (w_wdog_expire || (w_out_nxt == '0)) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state   <= S_IDLE;
            r_seq     <= '0;
            r_count   <= '0;
            r_out     <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_wdog    <= '0;
            r_err     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_seq     <= '0;
                r_count   <= bus.start_count;
                r_out     <= '0;
                r_wptr    <= '0;
                r_rptr    <= '0;
                r_wdog    <= '0;
                r_err     <= '0;
                r_timeout <= 1'b0;
            end else if (w_wdog_expire) begin
                // Abort: drop everything still owed so heard__RDY falls immediately.
                r_timeout <= 1'b1;
                r_out     <= '0;
                r_wptr    <= '0;
                r_rptr    <= '0;
                r_wdog    <= '0;
            end else begin
                if (w_say_fire) begin
                    r_seq  <= r_seq + 8'd1;
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_heard_fire) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                r_out <= w_out_nxt;
                if (w_heard_fire) begin
                    r_wdog <= '0;
                end else if (w_wdog_cnt) begin
                    r_wdog <= r_wdog + 16'd1;
                end
                if (w_mismatch && (r_err != 8'hFF)) begin
                    r_err <= r_err + 8'd1;
                end
            end
        end
    end

    // Expected-value storage; contents are don't-care until written, pointers carry validity.
    always_ff @(posedge CLK) begin
        if (w_say_fire) begin
            r_fifo[r_wptr] <= {w_say_v, w_say_meth};
        end
    end

    assign bus.start__RDY       = (r_state == S_IDLE) || (r_state == S_DONE);
    assign bus.request_say__ENA = w_say_fire;
    assign bus.request_say_meth = w_say_meth;
    assign bus.request_say_v    = w_say_v;
    assign bus.ind_heard__RDY   = w_heard_rdy;
    assign bus.done             = (r_state == S_DONE);
    assign bus.pass             = (r_state == S_DONE) && (r_err == 8'd0) && !r_timeout;
    assign bus.timeout          = r_timeout;
    assign bus.err_count        = r_err;

endmodule

// File: doc/ivector_driver.md
IVECTOR_DRIVER -- requirements
Module: ivector_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, max outstanding say requests awaiting heard (power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 1023, idle cycles without heard before abort (16-bit).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start__ENA  input  1  begin a run; accepted only when start__RDY=1.
REQ-006 SHALL have port start$count  input  8  number of say requests in the run.
REQ-007 SHALL have port start__RDY  output  1  high in IDLE or DONE.
REQ-008 SHALL have port request$say__ENA  output  1  issue one say request.
REQ-009 SHALL have port request$say$meth  output  6  meth field of issued request.
REQ-010 SHALL have port request$say$v  output  4  v field of issued request.
REQ-011 SHALL have port request$say__RDY  input  1  downstream can accept say.
REQ-012 SHALL have port ind$heard__ENA  input  1  heard indication valid.
REQ-013 SHALL have port ind$heard$meth  input  6  returned meth.
REQ-014 SHALL have port ind$heard$v  input  4  returned v.
REQ-015 SHALL have port ind$heard__RDY  output  1  ready for heard; high iff outstanding>0.
REQ-016 SHALL have port done  output  1  run complete (DONE state).
REQ-017 SHALL have port pass  output  1  done, zero errors, no timeout.
REQ-018 SHALL have port timeout  output  1  run aborted by watchdog; valid while done=1.
REQ-019 SHALL have port err_count  output  8  mismatches this run, saturating at 255.

Function
REQ-020 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-021 SHALL, on accepted start, clear seq, outstanding, err_count, timeout, watchdog, load count; go RUN if count!=0, else DONE directly.
REQ-022 SHALL drive request$say__ENA = RUN && seq!=count && outstanding!=DEPTH && request$say__RDY, same cycle, no registered bubble.
REQ-023 SHALL drive meth = seq[5:0], v = seq[3:0] XOR 4'b0101, seq being the 8-bit issue index of the current request.
REQ-024 SHALL, on each say handshake, push {v,meth} into a DEPTH-entry expected FIFO and increment seq.
REQ-025 SHALL, on heard handshake (ENA && RDY), pop expected FIFO and compare {v,meth}; mismatch increments err_count unless at 255.
REQ-026 SHALL handle simultaneous issue and heard in one cycle: push and pop both occur, outstanding unchanged; heard-pop legal even when FIFO is full.
REQ-027 SHALL ignore ind$heard__ENA when ind$heard__RDY=0 (no pop, no error).
REQ-028 SHALL transition RUN->DRAIN in the cycle after the final say handshake (seq==count).
REQ-029 SHALL transition DRAIN->DONE in the cycle after outstanding reaches 0, including when final heard coincides with final say.
REQ-030 SHALL increment watchdog each RUN/DRAIN cycle with outstanding>0 and no heard handshake; clear on any heard handshake.
REQ-031 SHALL, when watchdog reaches TIMEOUT, set timeout=1, flush FIFO (outstanding=0), enter DONE.
REQ-032 SHALL hold done, pass, timeout, err_count stable in DONE until next accepted start.
REQ-033 SHALL ignore start__ENA in RUN/DRAIN.
REQ-034 SHALL keep outstanding as a log2(DEPTH)+1-bit count; no wrap beyond DEPTH.

Reset
REQ-035 SHALL, when nRST=0 at a clock edge, enter IDLE, clear seq, count, outstanding, FIFO pointers, watchdog, err_count, timeout.
REQ-036 SHALL during/after reset output start__RDY=1, request$say__ENA=0, ind$heard__RDY=0, done=0, pass=0, timeout=0, err_count=0.
REQ-037 SHALL abandon a run mid-operation on reset; no partial results retained.

Verification
REQ-038 Loopback via 1-entry FIFO, count=5, all RDY high -> says meth 0..4 / v 5,4,7,6,1; 5 heard; done=1, pass=1, err_count=0.
REQ-039 count=0 start -> DONE next cycle, pass=1, no say issued.
REQ-040 Responder holds heard off, DEPTH=4, count=10 -> exactly 4 says issued, then ENA low until heard resumes.
REQ-041 Responder corrupts v of 3rd heard (expected v=7, returns 0) -> err_count=1, pass=0, done=1.
REQ-042 Responder never answers, TIMEOUT=15, count=2 -> timeout=1 done=1 pass=0 after 15 idle cycles; start__RDY=1.
REQ-043 nRST low during DRAIN with 2 outstanding -> IDLE, all outputs at reset values; new start count=1 completes pass=1.
